bc_rx_buf_ctrl: RTL and testbench

- Circular-buffer controller for the BC receive RAM (1024 x 40 dual-port, byte-enabled, non-pipelined output).
- Port A is write-only: it stores each word from the 1553 decoder with error flags and a timestamp.
- Port B is read-only: it serves host pop requests in FIFO order.
- Tracks occupancy, flags overflow and counts dropped words; sits between the Manchester decoder, the RAM and the host register interface.

---
 rtl/bc_rx_buf_ctrl_pkg.sv | 21 ++
 rtl/bc_rx_buf_ctrl_if.sv | 31 +++
 rtl/bc_rx_buf_ctrl_ts_counter.sv | 20 ++
 rtl/bc_rx_buf_ctrl.sv | 137 +++++++++++++
 tb/tb_bc_rx_buf_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/bc_rx_buf_ctrl_pkg.sv
// Shared definitions for the BC receive buffer: stored-word layout,
// read-FSM states and RAM byte-enable constants.
package bc_rx_buf_pkg;

  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned SYNC_BIT = 16;
  localparam int unsigned PAR_BIT  = 17;
  localparam int unsigned MAN_BIT  = 18;
  localparam int unsigned TS_LSB   = 24;
  localparam int unsigned TS_W     = 16;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_CAPT  = 2'd2
  } rd_state_t;

  localparam logic [3:0] BYTE_EN_ALL  = '1;
  localparam logic [3:0] BYTE_EN_NONE = '0;

endpackage

// File: rtl/bc_rx_buf_ctrl_if.sv
// Dual-port receive RAM bus: port A write-only, port B read-only.
interface bc_rx_buf_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 40
);

  logic [ADDR_W-1:0] RAM_A_ADDR;
  logic [DATA_W-1:0] RAM_A_DIN;
  logic              RAM_A_WEN;
  logic [3:0]        RAM_A_WBYTE_EN;
  logic              RAM_A_REN;
  logic [ADDR_W-1:0] RAM_B_ADDR;
  logic              RAM_B_REN;
  logic              RAM_B_BLK_EN;
  logic              RAM_B_WEN;
  logic [3:0]        RAM_B_WBYTE_EN;
  logic [DATA_W-1:0] RAM_B_DOUT;

  modport master (
    output RAM_A_ADDR, RAM_A_DIN, RAM_A_WEN, RAM_A_WBYTE_EN, RAM_A_REN,
    output RAM_B_ADDR, RAM_B_REN, RAM_B_BLK_EN, RAM_B_WEN, RAM_B_WBYTE_EN,
    input  RAM_B_DOUT
  );

  modport slave (
    input  RAM_A_ADDR, RAM_A_DIN, RAM_A_WEN, RAM_A_WBYTE_EN, RAM_A_REN,
    input  RAM_B_ADDR, RAM_B_REN, RAM_B_BLK_EN, RAM_B_WEN, RAM_B_WBYTE_EN,
    output RAM_B_DOUT
  );

endinterface

// File: rtl/bc_rx_buf_ctrl_ts_counter.sv
// Free-running 16-bit timestamp, advanced by the 1 us tick strobe.
module bc_rx_ts_counter
  import bc_rx_buf_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            TS_TICK,
  output logic [TS_W-1:0] TS
);

  logic [TS_W-1:0] r_ts;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          r_ts <= '0;
    else if (TS_TICK) r_ts <= r_ts + TS_W'(1);
  end

  assign TS = r_ts;

endmodule

// File: rtl/bc_rx_buf_ctrl.sv
// Circular-buffer controller for the BC receive RAM: decoder words are
// timestamped and written via port A, host pops are served via port B.
module bc_rx_buf_ctrl
  import bc_rx_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 40,
  parameter int unsigned DROP_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                TS_TICK,
  input  logic                RX_VALID,
  input  logic [15:0]         RX_DATA,
  input  logic                RX_SYNC_CMD,
  input  logic                RX_PAR_ERR,
  input  logic                RX_MAN_ERR,
  input  logic                RD_REQ,
  output logic [DATA_W-1:0]   RD_DATA,
  output logic                RD_VALID,
  output logic                RD_EMPTY,
  output logic [ADDR_W:0]     FILL_LEVEL,
  output logic                OVERFLOW,
  output logic [DROP_W-1:0]   DROP_CNT,
  input  logic                FLUSH,
  bc_rx_buf_ctrl_if.master    ram
);

  localparam logic [ADDR_W+1:0] DEPTH = (ADDR_W+2)'(1) << ADDR_W;

  logic [TS_W-1:0]   w_ts;
  logic [DATA_W-1:0] w_word;
  logic [ADDR_W+1:0] w_occ;
  logic              w_accept;
  logic              w_commit;
  logic              w_capt;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_fill;
  logic              r_wr_pend;
  logic [DATA_W-1:0] r_wr_word;
  logic              r_ovf;
  logic [DROP_W-1:0] r_drop;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  rd_state_t         r_state;

  bc_rx_ts_counter u_ts (
    .CLK     (CLK),
    .RST     (RST),
    .TS_TICK (TS_TICK),
    .TS      (w_ts)
  );

  always_comb begin
    w_word                       = '0;
    w_word[DATA_LSB +: 16]       = RX_DATA;
    w_word[SYNC_BIT]             = RX_SYNC_CMD;
    w_word[PAR_BIT]              = RX_PAR_ERR;
    w_word[MAN_BIT]              = RX_MAN_ERR;
    w_word[TS_LSB +: TS_W]       = w_ts;
  end

  // The word still in the write register counts against capacity.
  assign w_occ    = {1'b0, r_fill} + (ADDR_W+2)'(r_wr_pend);
  assign w_accept = RX_VALID && (w_occ < DEPTH);
  assign w_commit = r_wr_pend;
  assign w_capt   = (r_state == R_CAPT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_wr_pend  <= 1'b0;
      r_wr_word  <= '0;
      r_ovf      <= 1'b0;
      r_drop     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_state    <= R_IDLE;
    end else if (FLUSH) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_wr_pend  <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop     <= '0;
      r_rd_valid <= 1'b0;
      r_state    <= R_IDLE;
    end else begin
      r_wr_pend <= w_accept;
      if (w_accept) r_wr_word <= w_word;
      if (RX_VALID && !w_accept) begin
        r_ovf <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + DROP_W'(1);
      end
      if (w_commit) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);

      if (w_commit && !w_capt)      r_fill <= r_fill + (ADDR_W+1)'(1);
      else if (!w_commit && w_capt) r_fill <= r_fill - (ADDR_W+1)'(1);

      r_rd_valid <= 1'b0;
      case (r_state)
        R_IDLE:  if (RD_REQ && (r_fill != '0)) r_state <= R_ISSUE;
        R_ISSUE: r_state <= R_CAPT;
        R_CAPT: begin
          r_rd_data  <= ram.RAM_B_DOUT;
          r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
          r_rd_valid <= 1'b1;
          r_state    <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign RD_DATA    = r_rd_data;
  assign RD_VALID   = r_rd_valid;
  assign RD_EMPTY   = (r_fill == '0);
  assign FILL_LEVEL = r_fill;
  assign OVERFLOW   = r_ovf;
  assign DROP_CNT   = r_drop;

  assign ram.RAM_A_ADDR     = r_wr_ptr;
  assign ram.RAM_A_DIN      = r_wr_word;
  assign ram.RAM_A_WEN      = r_wr_pend;
  assign ram.RAM_A_WBYTE_EN = BYTE_EN_ALL;
  assign ram.RAM_A_REN      = 1'b0;
  assign ram.RAM_B_ADDR     = r_rd_ptr;
  assign ram.RAM_B_REN      = (r_state == R_ISSUE);
  assign ram.RAM_B_BLK_EN   = (r_state == R_ISSUE);
  assign ram.RAM_B_WEN      = 1'b0;
  assign ram.RAM_B_WBYTE_EN = BYTE_EN_NONE;

endmodule

// File: tb/tb_bc_rx_buf_ctrl.sv
// Directed bench for bc_rx_buf_ctrl with a behavioural 1024x40 RAM.
module tb_bc_rx_buf_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        TS_TICK, RX_VALID, RX_SYNC_CMD, RX_PAR_ERR, RX_MAN_ERR;
  logic [15:0] RX_DATA;
  logic        RD_REQ, FLUSH;
  logic [39:0] RD_DATA;
  logic        RD_VALID, RD_EMPTY, OVERFLOW;
  logic [10:0] FILL_LEVEL;
  logic [7:0]  DROP_CNT;

  bc_rx_buf_ctrl_if #(.ADDR_W(10), .DATA_W(40)) ram_if ();

  bc_rx_buf_ctrl #(.ADDR_W(10), .DATA_W(40), .DROP_W(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .TS_TICK     (TS_TICK),
    .RX_VALID    (RX_VALID),
    .RX_DATA     (RX_DATA),
    .RX_SYNC_CMD (RX_SYNC_CMD),
    .RX_PAR_ERR  (RX_PAR_ERR),
    .RX_MAN_ERR  (RX_MAN_ERR),
    .RD_REQ      (RD_REQ),
    .RD_DATA     (RD_DATA),
    .RD_VALID    (RD_VALID),
    .RD_EMPTY    (RD_EMPTY),
    .FILL_LEVEL  (FILL_LEVEL),
    .OVERFLOW    (OVERFLOW),
    .DROP_CNT    (DROP_CNT),
    .FLUSH       (FLUSH),
    .ram         (ram_if)
  );

  always #5 CLK = ~CLK;

  logic [39:0] mem [1024];
  always @(posedge CLK) begin
    if (ram_if.RAM_A_WEN) mem[ram_if.RAM_A_ADDR] <= ram_if.RAM_A_DIN;
    if (ram_if.RAM_B_REN) ram_if.RAM_B_DOUT <= mem[ram_if.RAM_B_ADDR];
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] ts_model = 16'h0;
  logic [39:0] q [$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [39:0] mk_word(input logic [15:0] d, input logic s, p, m,
                                          input logic [15:0] ts);
    return {ts, 5'b0, m, p, s, d};
  endfunction

  // Presents one word for one cycle; returns at the following negedge.
  task automatic wr(input logic [15:0] d, input logic s, input logic tick, input logic push);
    RX_VALID = 1'b1; RX_DATA = d; RX_SYNC_CMD = s;
    RX_PAR_ERR = d[0]; RX_MAN_ERR = d[1]; TS_TICK = tick;
    if (push) q.push_back(mk_word(d, s, d[0], d[1], ts_model));
    @(negedge CLK);
    if (tick) ts_model = ts_model + 16'd1;
    RX_VALID = 1'b0; TS_TICK = 1'b0;
  endtask

  task automatic pop(input string tag);
    logic [39:0] exp;
    exp = (q.size() > 0) ? q.pop_front() : 40'h0;
    RD_REQ = 1'b1;
    @(negedge CLK);
    RD_REQ = 1'b0;
    @(negedge CLK);
    check({tag, "_early"}, RD_VALID, 1'b0);
    @(negedge CLK);
    check({tag, "_valid"}, RD_VALID, 1'b1);
    check({tag, "_data"}, RD_DATA, exp);
    @(negedge CLK);
    check({tag, "_1cyc"}, RD_VALID, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; TS_TICK = 0; RX_VALID = 0; RX_DATA = '0; RX_SYNC_CMD = 0;
    RX_PAR_ERR = 0; RX_MAN_ERR = 0; RD_REQ = 0; FLUSH = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Reset state
    check("rst_fill", FILL_LEVEL, 0);
    check("rst_empty", RD_EMPTY, 1);
    check("rst_ovf", OVERFLOW, 0);
    check("rst_drop", DROP_CNT, 0);
    check("rst_rdvalid", RD_VALID, 0);
    check("rst_rddata", RD_DATA, 0);
    check("rst_wen", ram_if.RAM_A_WEN, 0);
    check("rst_ren", ram_if.RAM_B_REN, 0);
    check("a_wbyte", ram_if.RAM_A_WBYTE_EN, 4'hF);
    check("b_wbyte", ram_if.RAM_B_WBYTE_EN, 4'h0);

    // Single word with timestamp 3
    TS_TICK = 1'b1;
    repeat (3) @(negedge CLK);
    TS_TICK = 1'b0;
    ts_model = 16'd3;
    RX_VALID = 1'b1; RX_DATA = 16'hA5A5; RX_SYNC_CMD = 1'b1;
    q.push_back(40'h00_0301A5A5);
    @(negedge CLK);
    RX_VALID = 1'b0; RX_SYNC_CMD = 1'b0;
    check("t1_wen", ram_if.RAM_A_WEN, 1);
    check("t1_addr", ram_if.RAM_A_ADDR, 0);
    check("t1_din", ram_if.RAM_A_DIN, 40'h00_0301A5A5);
    check("t1_fill_pre", FILL_LEVEL, 0);
    @(negedge CLK);
    check("t1_fill", FILL_LEVEL, 1);
    check("t1_wen_off", ram_if.RAM_A_WEN, 0);

    // Three more words, then pop all four in order
    wr(16'h1111, 1'b0, 1'b1, 1'b1);
    wr(16'h2222, 1'b1, 1'b0, 1'b1);
    wr(16'h3303, 1'b0, 1'b1, 1'b1);
    @(negedge CLK);
    check("t2_fill", FILL_LEVEL, 4);
    for (int i = 0; i < 4; i++) pop("t2_pop");
    check("t2_empty", RD_EMPTY, 1);
    check("t2_fill0", FILL_LEVEL, 0);

    // Fill to DEPTH, then drop two
    for (int i = 0; i < 1026; i++) wr(16'(i), 1'b0, 1'b0, i < 1024);
    check("t3_fill", FILL_LEVEL, 1024);
    check("t3_ovf", OVERFLOW, 1);
    check("t3_drop", DROP_CNT, 2);
    check("t3_notempty", RD_EMPTY, 0);
    pop("t3_first");
    check("t3_fill_after", FILL_LEVEL, 1023);
    while (q.size() > 0) pop("t3_drain");
    check("t3_empty", RD_EMPTY, 1);

    // Interleaved writes and reads across pointer wrap
    wr(16'hF000, 1'b1, 1'b0, 1'b1);
    wr(16'hF001, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1030; i++) begin
      wr(16'h4000 + 16'(i), 1'(i), 1'(i % 7 == 0), 1'b1);
      pop("t4_pop");
    end
    while (q.size() > 0) pop("t4_drain");
    check("t4_empty", RD_EMPTY, 1);
    check("t4_ovf_sticky", OVERFLOW, 1);

    // Write commit and read capture in the same cycle at fill 5
    for (int i = 0; i < 5; i++) wr(16'h5000 + 16'(i), 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    check("t5_fill_pre", FILL_LEVEL, 5);
    RD_REQ = 1'b1;
    @(negedge CLK);
    RD_REQ = 1'b0;
    RX_VALID = 1'b1; RX_DATA = 16'h5AAA; RX_SYNC_CMD = 1'b0;
    RX_PAR_ERR = 1'b0; RX_MAN_ERR = 1'b1;
    @(negedge CLK);
    RX_VALID = 1'b0; RX_MAN_ERR = 1'b0;
    check("t5_state_capt_fill", FILL_LEVEL, 5);
    @(negedge CLK);
    check("t5_fill", FILL_LEVEL, 5);
    check("t5_valid", RD_VALID, 1);
    check("t5_data", RD_DATA, q.pop_front());
    q.push_back(mk_word(16'h5AAA, 1'b0, 1'b0, 1'b1, ts_model));

    // Flush during R_ISSUE with 10 entries
    for (int i = 0; i < 5; i++) wr(16'h6000 + 16'(i), 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    check("t6_fill10", FILL_LEVEL, 10);
    RD_REQ = 1'b1;
    @(negedge CLK);
    RD_REQ = 1'b0;
    check("t6_issue_ren", ram_if.RAM_B_REN, 1);
    FLUSH = 1'b1; RX_VALID = 1'b1; RX_DATA = 16'hDEAD;
    @(negedge CLK);
    FLUSH = 1'b0; RX_VALID = 1'b0;
    q.delete();
    check("t6_fill", FILL_LEVEL, 0);
    check("t6_ovf", OVERFLOW, 0);
    check("t6_drop", DROP_CNT, 0);
    check("t6_empty", RD_EMPTY, 1);
    check("t6_wen", ram_if.RAM_A_WEN, 0);
    check("t6_ren", ram_if.RAM_B_REN, 0);
    for (int i = 0; i < 3; i++) begin
      check("t6_no_valid", RD_VALID, 0);
      @(negedge CLK);
    end
    wr(16'h7777, 1'b1, 1'b0, 1'b1);
    check("t6_wr_addr", ram_if.RAM_A_ADDR, 0);
    check("t6_wr_din", ram_if.RAM_A_DIN, mk_word(16'h7777, 1'b1, 1'b1, 1'b1, ts_model));
    @(negedge CLK);
    pop("t6_pop");

    // Asynchronous reset mid-operation
    wr(16'h8888, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    check("t7_fill_pre", FILL_LEVEL, 1);
    RST = 1'b1;
    #1;
    check("t7_fill", FILL_LEVEL, 0);
    check("t7_empty", RD_EMPTY, 1);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
